// File: rtl/div_pkg.sv
// Shared types, special-case codes and two's-complement helpers for the sequential divider.
package div_pkg;

    // Widest operand the helpers handle. Callers zero-extend into it and cast the result back.
    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StSpecial
    } div_state_e;

    localparam logic [1:0] SpNone     = 2'd0;
    localparam logic [1:0] SpDivZero  = 2'd1;
    localparam logic [1:0] SpOverflow = 2'd2;

    function automatic logic [MAX_W-1:0] neg2c(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    // The sign bit is x[w-1]. Only the low w bits of the result are meaningful.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input int unsigned w);
        return x[MAX_IDX_W'(w - 1)] ? neg2c(x) : x;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           neg;

    always_comb begin
        shifted = {a, q[WIDTH-1]};
        trial   = shifted - {1'b0, m};
        // A < M always holds, so a set top bit in shifted means shifted >= M; otherwise the
        // trial sign bit is the true sign.
        neg     = ~shifted[WIDTH] & trial[WIDTH];
        a_next  = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {q[WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed or unsigned per operation.
// Start/done handshake, synchronous abort, divide-by-zero and signed-overflow detection.
module seq_divider_param
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1) {1'b0}}};
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, q_q, m_q;
    logic             signed_q, dd_neg_q, dv_neg_q;
    logic [1:0]       spec_q;

    logic [WIDTH-1:0] a_next, q_next;
    logic [WIDTH-1:0] dd_mag, dv_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             div_zero, sgn_ovf;

    always_comb begin
        dd_mag   = is_signed ? WIDTH'(abs_val(MAX_W'(dividend), WIDTH)) : dividend;
        dv_mag   = is_signed ? WIDTH'(abs_val(MAX_W'(divisor), WIDTH)) : divisor;
        div_zero = (divisor == '0);
        sgn_ovf  = is_signed && (dividend == MinVal) && (divisor == '1);
        q_fix    = (signed_q && (dd_neg_q != dv_neg_q)) ? WIDTH'(neg2c(MAX_W'(q_q))) : q_q;
        r_fix    = (signed_q && dd_neg_q) ? WIDTH'(neg2c(MAX_W'(a_q))) : a_q;
    end

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .q      (q_q),
        .m      (m_q),
        .a_next (a_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            signed_q    <= 1'b0;
            dd_neg_q    <= 1'b0;
            dv_neg_q    <= 1'b0;
            spec_q      <= SpNone;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt_q    <= '0;
                        signed_q <= is_signed;
                        dd_neg_q <= dividend[WIDTH-1];
                        dv_neg_q <= divisor[WIDTH-1];
                        a_q      <= '0;
                        m_q      <= dv_mag;
                        // Divide by zero reports the dividend as given, so park the raw value.
                        q_q      <= div_zero ? dividend : dd_mag;
                        if (div_zero) begin
                            spec_q  <= SpDivZero;
                            state_q <= StSpecial;
                        end else if (sgn_ovf) begin
                            spec_q  <= SpOverflow;
                            state_q <= StSpecial;
                        end else begin
                            spec_q  <= SpNone;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        a_q <= a_next;
                        q_q <= q_next;
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            state_q <= StFixup;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StFixup: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                    if (!abort) begin
                        done        <= 1'b1;
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                StSpecial: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                    if (!abort) begin
                        done <= 1'b1;
                        if (spec_q == SpDivZero) begin
                            quotient    <= '1;
                            remainder   <= q_q;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else begin
                            quotient    <= MinVal;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench for seq_divider_param: directed table, corner sequences, random vs. model.
module tb_seq_divider_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n;
    logic        start32, abort32, sg32;
    logic [31:0] dd32, dv32;
    logic        busy32, done32, dz32, ov32;
    logic [31:0] q32, r32;
    logic        start8, abort8, sg8;
    logic [7:0]  dd8, dv8;
    logic        busy8, done8, dz8, ov8;
    logic [7:0]  q8, r8;

    seq_divider_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .clr_n(clr_n), .start(start32), .abort(abort32), .is_signed(sg32),
        .dividend(dd32), .divisor(dv32), .busy(busy32), .done(done32), .quotient(q32),
        .remainder(r32), .div_by_zero(dz32), .overflow(ov32)
    );

    seq_divider_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .abort(abort8), .is_signed(sg8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8), .quotient(q8),
        .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: plain integer division, truncating toward zero, plus the two special cases.
    function automatic void ref_div(input int w, input logic [63:0] dd_in, dv_in, input bit sg,
                                    output logic [63:0] q, r, output bit dz, ov);
        logic [63:0] mask, dd, dv, minv;
        longint sdd, sdv;
        mask = (64'd1 << w) - 64'd1;
        minv = 64'd1 << (w - 1);
        dd = dd_in & mask;
        dv = dv_in & mask;
        dz = 0;
        ov = 0;
        if (dv == 0) begin
            q = mask; r = dd; dz = 1;
        end else if (sg && dd == minv && dv == mask) begin
            q = minv; r = 0; ov = 1;
        end else if (sg) begin
            sdd = (dd & minv) != 0 ? longint'(dd) - (longint'(1) << w) : longint'(dd);
            sdv = (dv & minv) != 0 ? longint'(dv) - (longint'(1) << w) : longint'(dv);
            q = 64'(sdd / sdv) & mask;
            r = 64'(sdd % sdv) & mask;
        end else begin
            q = dd / dv; r = dd % dv;
        end
    endfunction

    function automatic void drive(input int w, input logic s, a, sg,
                                  input logic [63:0] dd, dv);
        if (w == 8) begin
            start8 = s; abort8 = a; sg8 = sg; dd8 = dd[7:0]; dv8 = dv[7:0];
        end else begin
            start32 = s; abort32 = a; sg32 = sg; dd32 = dd[31:0]; dv32 = dv[31:0];
        end
    endfunction

    function automatic void rd(input int w, output logic b, d, output logic [63:0] q, r,
                               output logic z, o);
        if (w == 8) begin
            b = busy8; d = done8; q = {56'b0, q8}; r = {56'b0, r8}; z = dz8; o = ov8;
        end else begin
            b = busy32; d = done32; q = {32'b0, q32}; r = {32'b0, r32}; z = dz32; o = ov32;
        end
    endfunction

    // Issue one op and wait for done. Ends #1 after the done edge, so a caller can start again
    // in the done cycle with immediate=1.
    task automatic do_op(input int w, input logic [63:0] dd, dv, input bit sg,
                         input logic [63:0] eq, er, input bit edz, eov,
                         input bit immediate, with_abort, input string name);
        int n, lat, bad_busy;
        logic b, d, z, o;
        logic [63:0] q, r;
        lat = (edz || eov) ? 2 : w + 2;
        bad_busy = 0;
        if (!immediate) @(negedge clk);
        drive(w, 1, with_abort, sg, dd, dv);
        @(posedge clk);
        #1;
        drive(w, 0, 0, sg, dd, dv);
        n = 1;
        rd(w, b, d, q, r, z, o);
        check({name, " busy_after_start"}, 64'(b), 1);
        while (!d && n < w + 10) begin
            @(posedge clk);
            #1;
            n++;
            rd(w, b, d, q, r, z, o);
            if (!d && !b) bad_busy++;
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " busy_drop"}, 64'(bad_busy), 0);
        check({name, " busy_in_done"}, 64'(b), 0);
        check({name, " quotient"}, q, eq);
        check({name, " remainder"}, r, er);
        check({name, " div_by_zero"}, 64'(z), 64'(edz));
        check({name, " overflow"}, 64'(o), 64'(eov));
    endtask

    task automatic rand_op(input int w, input int idx);
        logic [63:0] mask, dd, dv, q, r;
        bit sg, dz, ov;
        int sel;
        mask = (64'd1 << w) - 64'd1;
        sg = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        dd = {32'($urandom), 32'($urandom)} & mask;
        dv = {32'($urandom), 32'($urandom)} & mask;
        if (sel == 0) dv = 0;
        else if (sel == 1) begin dd = 64'd1 << (w - 1); dv = mask; end
        else if (sel <= 4) dv = 64'($urandom_range(1, 15));
        else if (sel == 5) dv = (-64'($urandom_range(1, 15))) & mask;
        ref_div(w, dd, dv, sg, q, r, dz, ov);
        do_op(w, dd, dv, sg, q, r, dz, ov, 1'($urandom_range(0, 1)), 0,
              $sformatf("rand%0d_w%0d", idx, w));
    endtask

    typedef struct {
        int          w;
        logic [63:0] dd, dv;
        bit          sg;
        logic [63:0] q, r;
        bit          dz, ov;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int seen;
        int n;
        logic b, d, z, o;
        logic [63:0] q, r;

        tbl[0]  = '{32, 64'd100, 64'd7, 0, 64'd14, 64'd2, 0, 0};
        tbl[1]  = '{32, 64'hFFFFFF9C, 64'd7, 1, 64'hFFFFFFF2, 64'hFFFFFFFE, 0, 0};
        tbl[2]  = '{32, 64'd100, 64'hFFFFFFF9, 1, 64'hFFFFFFF2, 64'd2, 0, 0};
        tbl[3]  = '{32, 64'hFFFFFF9C, 64'hFFFFFFF9, 1, 64'd14, 64'hFFFFFFFE, 0, 0};
        tbl[4]  = '{32, 64'h1234, 64'd0, 0, 64'hFFFFFFFF, 64'h1234, 1, 0};
        tbl[5]  = '{32, 64'h80000000, 64'hFFFFFFFF, 1, 64'h80000000, 64'd0, 0, 1};
        tbl[6]  = '{32, 64'h80000000, 64'hFFFFFFFF, 0, 64'd0, 64'h80000000, 0, 0};
        tbl[7]  = '{32, 64'hFFFFFF9C, 64'd0, 1, 64'hFFFFFFFF, 64'hFFFFFF9C, 1, 0};
        tbl[8]  = '{8, 64'd255, 64'd16, 0, 64'd15, 64'd15, 0, 0};
        tbl[9]  = '{8, 64'h80, 64'hFF, 1, 64'h80, 64'd0, 0, 1};
        tbl[10] = '{8, 64'hF9, 64'd2, 1, 64'hFD, 64'hFF, 0, 0};

        clr_n = 1'b0;
        drive(32, 0, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0, 0);
        #2;
        for (int w = 8; w <= 32; w += 24) begin
            rd(w, b, d, q, r, z, o);
            check($sformatf("reset_w%0d busy", w), 64'(b), 0);
            check($sformatf("reset_w%0d done", w), 64'(d), 0);
            check($sformatf("reset_w%0d quotient", w), q, 0);
            check($sformatf("reset_w%0d remainder", w), r, 0);
            check($sformatf("reset_w%0d flags", w), {62'b0, z, o}, 0);
        end
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op(tbl[i].w, tbl[i].dd, tbl[i].dv, tbl[i].sg, tbl[i].q, tbl[i].r,
                  tbl[i].dz, tbl[i].ov, 0, 0, $sformatf("vec%0d", i));

        // Start while busy is ignored; the original op completes on time.
        @(negedge clk);
        drive(32, 1, 0, 0, 100, 7);
        @(posedge clk);
        #1;
        drive(32, 0, 0, 0, 0, 0);
        n = 1;
        repeat (3) begin @(posedge clk); #1; n++; end
        drive(32, 1, 0, 0, 50, 5);
        @(posedge clk);
        #1;
        n++;
        drive(32, 0, 0, 0, 0, 0);
        while (!done32 && n < 50) begin @(posedge clk); #1; n++; end
        check("busy_start_ignored latency", 64'(n), 34);
        check("busy_start_ignored quotient", 64'(q32), 14);
        check("busy_start_ignored remainder", 64'(r32), 2);
        // Back-to-back start in the done cycle.
        do_op(32, 200, 9, 0, 22, 2, 0, 0, 1, 0, "back_to_back");

        // Abort mid-CALC: busy drops on the abort edge, no done, old results kept.
        @(negedge clk);
        drive(32, 1, 0, 0, 1000, 3);
        @(posedge clk);
        #1;
        drive(32, 0, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        abort32 = 1'b1;
        @(posedge clk);
        #1;
        abort32 = 1'b0;
        check("abort_calc busy", 64'(busy32), 0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done32 || busy32) seen++; end
        check("abort_calc no_done", 64'(seen), 0);
        check("abort_calc quotient_held", 64'(q32), 22);
        check("abort_calc remainder_held", 64'(r32), 2);

        // Abort during SPECIAL.
        @(negedge clk);
        drive(32, 1, 0, 0, 5, 0);
        @(posedge clk);
        #1;
        drive(32, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        abort32 = 1'b0;
        seen = 0;
        repeat (4) begin if (done32 || busy32) seen++; @(posedge clk); #1; end
        check("abort_special no_done", 64'(seen), 0);
        check("abort_special quotient_held", 64'(q32), 22);
        check("abort_special div_by_zero", 64'(dz32), 0);

        // Start and abort together in IDLE: the start wins.
        do_op(32, 77, 5, 0, 15, 2, 0, 0, 0, 1, "start_with_abort");

        for (int i = 0; i < 150; i++) rand_op(32, i);
        for (int i = 0; i < 120; i++) rand_op(8, i);

        // Reset mid-CALC clears everything asynchronously on both instances.
        @(negedge clk);
        drive(8, 1, 0, 0, 200, 3);
        drive(32, 1, 0, 0, 1000, 7);
        @(posedge clk);
        #1;
        drive(8, 0, 0, 0, 0, 0);
        drive(32, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        for (int w = 8; w <= 32; w += 24) begin
            rd(w, b, d, q, r, z, o);
            check($sformatf("midreset_w%0d busy", w), 64'(b), 0);
            check($sformatf("midreset_w%0d done", w), 64'(d), 0);
            check($sformatf("midreset_w%0d quotient", w), q, 0);
            check($sformatf("midreset_w%0d remainder", w), r, 0);
            check($sformatf("midreset_w%0d flags", w), {62'b0, z, o}, 0);
        end
        @(negedge clk);
        clr_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done8 || busy8) seen++; end
        check("midreset_w8 no_done", 64'(seen), 0);
        do_op(8, 9, 3, 0, 3, 0, 0, 0, 0, 0, "after_reset_w8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
